// File: rtl/demux_1t8_buf.sv
// rtl/demux_1t8_buf.sv - buffered 1-to-8 demultiplexer with per-channel one-entry holding registers
module demux_1t8_buf #(
    parameter int W     = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       s,
    input  logic [W-1:0]     i,
    input  logic             i_valid,
    output logic             i_ready,
    output logic [W-1:0]     o0,
    output logic [W-1:0]     o1,
    output logic [W-1:0]     o2,
    output logic [W-1:0]     o3,
    output logic [W-1:0]     o4,
    output logic [W-1:0]     o5,
    output logic [W-1:0]     o6,
    output logic [W-1:0]     o7,
    output logic [7:0]       o_valid,
    input  logic [7:0]       o_ready,
    output logic [CNT_W-1:0] xfer_cnt
);

    logic [7:0]       full_q, full_d;
    logic [W-1:0]     data_q [8];
    logic [W-1:0]     data_d [8];
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       pop;
    logic             acc;

    // A full channel can still take a word when its consumer drains it in the same cycle.
    assign i_ready = ~full_q[s] | o_ready[s];
    assign acc     = i_valid & i_ready;
    assign pop     = full_q & o_ready;

    always_comb begin
        full_d = full_q;
        data_d = data_q;
        cnt_d  = cnt_q;
        for (int k = 0; k < 8; k++) begin
            if (acc && (s == 3'(k))) begin
                full_d[k] = 1'b1;
                data_d[k] = i;
            end else if (pop[k]) begin
                full_d[k] = 1'b0;
            end
        end
        if (acc) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q <= '0;
            cnt_q  <= '0;
            for (int k = 0; k < 8; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            full_q <= full_d;
            cnt_q  <= cnt_d;
            for (int k = 0; k < 8; k++) begin
                data_q[k] <= data_d[k];
            end
        end
    end

    assign o_valid  = full_q;
    assign xfer_cnt = cnt_q;
    assign o0 = data_q[0];
    assign o1 = data_q[1];
    assign o2 = data_q[2];
    assign o3 = data_q[3];
    assign o4 = data_q[4];
    assign o5 = data_q[5];
    assign o6 = data_q[6];
    assign o7 = data_q[7];

endmodule

// File: tb/tb_demux_1t8_buf.sv
// tb/tb_demux_1t8_buf.sv - directed and randomized checks of demux_1t8_buf against a channel-slot model
module tb_demux_1t8_buf;

    logic        clk;
    logic        rst;
    logic [2:0]  s;
    logic [31:0] i;
    logic        i_valid;
    logic [7:0]  o_ready;

    logic        i_ready, i_ready_n;
    logic [31:0] o0, o1, o2, o3, o4, o5, o6, o7;
    logic [31:0] n0, n1, n2, n3, n4, n5, n6, n7;
    logic [7:0]  o_valid, o_valid_n;
    logic [15:0] xfer_cnt;
    logic [3:0]  xfer_cnt_n;

    demux_1t8_buf #(.W(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .s(s), .i(i), .i_valid(i_valid), .i_ready(i_ready),
        .o0(o0), .o1(o1), .o2(o2), .o3(o3), .o4(o4), .o5(o5), .o6(o6), .o7(o7),
        .o_valid(o_valid), .o_ready(o_ready), .xfer_cnt(xfer_cnt)
    );

    demux_1t8_buf #(.W(32), .CNT_W(4)) dut_narrow (
        .clk(clk), .rst(rst), .s(s), .i(i), .i_valid(i_valid), .i_ready(i_ready_n),
        .o0(n0), .o1(n1), .o2(n2), .o3(n3), .o4(n4), .o5(n5), .o6(n6), .o7(n7),
        .o_valid(o_valid_n), .o_ready(o_ready), .xfer_cnt(xfer_cnt_n)
    );

    logic [31:0] ov [8];
    assign ov[0] = o0; assign ov[1] = o1; assign ov[2] = o2; assign ov[3] = o3;
    assign ov[4] = o4; assign ov[5] = o5; assign ov[6] = o6; assign ov[7] = o7;

    int n_chk  = 0;
    int n_pass = 0;

    // Model: each channel is a slot that is either empty or holds the last word delivered to it.
    bit          m_has  [8];
    logic [31:0] m_word [8];
    int          m_total;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 8; k++) begin
                m_has[k]  = 0;
                m_word[k] = '0;
            end
            m_total = 0;
        end else begin
            bit take;
            int dst;
            dst  = int'(s);
            take = i_valid && (!m_has[dst] || o_ready[dst]);
            for (int k = 0; k < 8; k++) begin
                if (m_has[k] && o_ready[k]) m_has[k] = 0;
            end
            if (take) begin
                m_has[dst]  = 1;
                m_word[dst] = i;
                m_total     = m_total + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            logic [7:0] exp_v;
            for (int k = 0; k < 8; k++) exp_v[k] = m_has[k];
            chk("o_valid", 64'(o_valid), 64'(exp_v));
            chk("o_valid_narrow", 64'(o_valid_n), 64'(exp_v));
            for (int k = 0; k < 8; k++) chk($sformatf("o%0d", k), 64'(ov[k]), 64'(m_word[k]));
            chk("i_ready", 64'(i_ready), 64'(!m_has[int'(s)] || o_ready[s]));
            chk("xfer_cnt", 64'(xfer_cnt), 64'(m_total % 65536));
            chk("xfer_cnt_narrow", 64'(xfer_cnt_n), 64'(m_total % 16));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic put(input logic [2:0] ch, input logic [31:0] d);
        s = ch; i = d; i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; s = '0; i = '0; i_valid = 1'b0; o_ready = '0;
        #12;
        rst = 1'b0;
        tick();

        // T1: asynchronous reset clears held word without a clock edge
        put(3'd3, 32'h11);
        chk("t1_loaded", 64'(o_valid), 64'h08);
        #1 rst = 1'b1;
        #1;
        chk("t1_rst_valid", 64'(o_valid), 64'h00);
        chk("t1_rst_o3", 64'(o3), 64'h0);
        chk("t1_rst_cnt", 64'(xfer_cnt), 64'h0);
        tick();
        rst = 1'b0;
        tick();

        // T2: single write, hold, pop
        put(3'd3, 32'hDEADBEEF);
        chk("t2_valid", 64'(o_valid), 64'h08);
        chk("t2_o3", 64'(o3), 64'hDEADBEEF);
        repeat (5) tick();
        chk("t2_held", 64'(o3), 64'hDEADBEEF);
        o_ready = 8'h08;
        tick();
        o_ready = 8'h00;
        chk("t2_popped", 64'(o_valid), 64'h00);
        chk("t2_cnt", 64'(xfer_cnt), 64'd1);

        // T3: backpressure then pop-and-refill in one cycle
        put(3'd5, 32'hAA);
        s = 3'd5; i = 32'h55; i_valid = 1'b1;
        #1 chk("t3_stall_ready", 64'(i_ready), 64'h0);
        tick();
        chk("t3_stall_o5", 64'(o5), 64'hAA);
        o_ready = 8'h20;
        #1 chk("t3_refill_ready", 64'(i_ready), 64'h1);
        tick();
        i_valid = 1'b0; o_ready = 8'h00;
        chk("t3_o5", 64'(o5), 64'h55);
        chk("t3_valid5", 64'(o_valid[5]), 64'h1);
        chk("t3_cnt", 64'(xfer_cnt), 64'd3);

        // T4: fill every channel, then a blocked write to channel 0
        o_ready = 8'hFF; tick(); o_ready = 8'h00;
        for (int k = 0; k < 8; k++) put(3'(k), 32'h100 + k);
        chk("t4_all_valid", 64'(o_valid), 64'hFF);
        for (int k = 0; k < 8; k++) chk($sformatf("t4_o%0d", k), 64'(ov[k]), 64'(32'h100 + k));
        s = 3'd0; i = 32'h200; i_valid = 1'b1;
        #1 chk("t4_blocked", 64'(i_ready), 64'h0);
        tick();
        chk("t4_still_blocked", 64'(o0), 64'h100);
        o_ready = 8'h01;
        #1 chk("t4_unblocked", 64'(i_ready), 64'h1);
        tick();
        i_valid = 1'b0; o_ready = 8'h00;
        chk("t4_o0", 64'(o0), 64'h200);

        // T5: pop channel 6 while writing channel 2
        o_ready = 8'h04; tick();
        o_ready = 8'h40;
        put(3'd2, 32'h22);
        o_ready = 8'h00;
        chk("t5_valid", 64'(o_valid), 64'hBF);
        chk("t5_o2", 64'(o2), 64'h22);
        chk("t5_o7", 64'(o7), 64'h107);

        // T6: 17 accepts wrap a 4-bit counter to 1
        #1 rst = 1'b1;
        tick();
        rst = 1'b0;
        o_ready = 8'hFF;
        for (int n = 0; n < 17; n++) put(3'($urandom_range(0, 7)), $urandom);
        chk("t6_narrow_wrap", 64'(xfer_cnt_n), 64'd1);
        chk("t6_wide", 64'(xfer_cnt), 64'd17);

        // Random traffic, checked every cycle by the compare process
        for (int n = 0; n < 3000; n++) begin
            i_valid = ($urandom_range(0, 3) != 0);
            if (i_valid && !i_ready) begin
                // a stalled producer holds s and i
            end else begin
                s = 3'($urandom_range(0, 7));
                i = $urandom;
            end
            o_ready = 8'($urandom) & 8'($urandom);
            tick();
        end
        i_valid = 1'b0; o_ready = 8'h00;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
